// File: rtl/rom_c_read_d_responder_if.sv
// Load stream and C / read-and-D request/response bundle for rom_c_read_d_responder.
interface rom_c_read_d_responder_if #(
    parameter int D_AW = 8,
    parameter int DW   = 8
);
    logic            load_start;
    logic            load_valid;
    logic [DW+1:0]   load_data;
    logic            load_ready;
    logic            load_done;
    logic            ce_rom_C;
    logic [1:0]      addr_rom_C;
    logic            ce_rom_read_and_D;
    logic [D_AW-1:0] addr_rom_read_and_D;
    logic [DW-1:0]   data;
    logic [DW-1:0]   d_i;
    logic [1:0]      read_i;
    logic            data_valid;
    logic            rd_valid;
    logic            ready;
    logic [7:0]      miss_cnt;

    modport master (
        output load_start, load_valid, load_data,
        output ce_rom_C, addr_rom_C, ce_rom_read_and_D, addr_rom_read_and_D,
        input  load_ready, load_done, data, d_i, read_i, data_valid, rd_valid,
        input  ready, miss_cnt
    );

    modport slave (
        input  load_start, load_valid, load_data,
        input  ce_rom_C, addr_rom_C, ce_rom_read_and_D, addr_rom_read_and_D,
        output load_ready, load_done, data, d_i, read_i, data_valid, rd_valid,
        output ready, miss_cnt
    );
endinterface

// File: rtl/rom_c_read_d_responder.sv
// C / read-and-D ROM responder: streamed table load, then 1-cycle registered reads.
// Define ROM_HOLD_DATA_EN to hold read data between served requests instead of zeroing it.
module rom_c_read_d_responder #(
    parameter int D_AW = 8,
    parameter int DW   = 8
) (
    input logic clk,
    input logic rst,
    rom_c_read_d_responder_if.slave bus
);
    // state  | meaning
    // IDLE   | after reset, waiting for load_start
    // LOAD_C | accepting the 4 C table words
    // LOAD_D | accepting the 2^D_AW read-and-D words
    // READY  | tables loaded, requests served
    typedef enum logic [1:0] {IDLE, LOAD_C, LOAD_D, READY} state_t;

    localparam logic [D_AW-1:0] D_LAST = '1;

    state_t          state;
    logic [D_AW-1:0] load_idx;
    logic [DW-1:0]   c_mem  [4];
    logic [DW+1:0]   rd_mem [2**D_AW];
    logic [8:0]      miss_sum;
    logic            srv_c;
    logic            srv_rd;
    logic            rd_we;

    assign bus.load_ready = (state == LOAD_C) || (state == LOAD_D);
    assign bus.ready      = (state == READY);

    always_comb begin
        miss_sum = {1'b0, bus.miss_cnt} + 9'(bus.ce_rom_C) + 9'(bus.ce_rom_read_and_D);
        srv_c    = (state == READY) && bus.ce_rom_C;
        srv_rd   = (state == READY) && bus.ce_rom_read_and_D;
        // a restart in the same cycle discards the word on the bus
        rd_we    = !rst && (state == LOAD_D) && bus.load_valid && !bus.load_start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            load_idx      <= '0;
            bus.load_done <= 1'b0;
            bus.miss_cnt  <= '0;
            for (int k = 0; k < 4; k++) c_mem[k] <= '0;
        end else begin
            bus.load_done <= 1'b0;
            if (state != READY)
                bus.miss_cnt <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
            if (bus.load_start) begin
                state    <= LOAD_C;
                load_idx <= '0;
            end else begin
                case (state)
                    LOAD_C: if (bus.load_valid) begin
                        c_mem[load_idx[1:0]] <= bus.load_data[DW-1:0];
                        if (load_idx[1:0] == 2'd3) begin
                            state    <= LOAD_D;
                            load_idx <= '0;
                        end else begin
                            load_idx <= load_idx + 1'b1;
                        end
                    end
                    LOAD_D: if (bus.load_valid) begin
                        if (load_idx == D_LAST) begin
                            state         <= READY;
                            load_idx      <= '0;
                            bus.load_done <= 1'b1;
                        end else begin
                            load_idx <= load_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_we) rd_mem[load_idx] <= bus.load_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data       <= '0;
            bus.d_i        <= '0;
            bus.read_i     <= '0;
            bus.data_valid <= 1'b0;
            bus.rd_valid   <= 1'b0;
        end else begin
            bus.data_valid <= srv_c;
            bus.rd_valid   <= srv_rd;
`ifdef ROM_HOLD_DATA_EN
            if (srv_c)  bus.data <= c_mem[bus.addr_rom_C];
            if (srv_rd) {bus.read_i, bus.d_i} <= rd_mem[bus.addr_rom_read_and_D];
`else
            bus.data <= srv_c ? c_mem[bus.addr_rom_C] : '0;
            if (srv_rd) {bus.read_i, bus.d_i} <= rd_mem[bus.addr_rom_read_and_D];
            else        {bus.read_i, bus.d_i} <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_rom_c_read_d_responder.sv
// Directed bench for rom_c_read_d_responder: reset, miss counting, load/restart, reads.
module tb_rom_c_read_d_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   early_done;

    always #5 clk = ~clk;

    rom_c_read_d_responder_if #(.D_AW(8), .DW(8)) bus ();

    rom_c_read_d_responder #(.D_AW(8), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [9:0] w);
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        tick();
    endtask

    function automatic logic [9:0] rd_word(input int i);
        logic [7:0] iv;
        iv = i[7:0];
        return {iv[1:0], iv ^ 8'h5A};
    endfunction

    logic [7:0] b2b_addr [3] = '{8'h00, 8'hFF, 8'h80};
    logic [1:0] b2b_c    [3] = '{2'd0, 2'd1, 2'd0};
    logic [7:0] b2b_cexp [3] = '{8'd10, 8'd20, 8'd10};
    logic [7:0] b2b_d    [3] = '{8'h5A, 8'hA5, 8'hDA};
    logic [1:0] b2b_r    [3] = '{2'd0, 2'd3, 2'd0};

    initial begin
        bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0;
        bus.ce_rom_C = 0; bus.addr_rom_C = '0;
        bus.ce_rom_read_and_D = 0; bus.addr_rom_read_and_D = '0;

        repeat (3) tick();
        check_val("rst_ready", bus.ready, 0);
        check_val("rst_load_ready", bus.load_ready, 0);
        check_val("rst_miss", bus.miss_cnt, 0);
        check_val("rst_data", bus.data, 0);
        check_val("rst_dv", bus.data_valid, 0);
        rst = 0;
        tick();

        bus.ce_rom_C = 1; bus.ce_rom_read_and_D = 1;
        repeat (3) tick();
        check_val("miss_6", bus.miss_cnt, 6);
        check_val("miss_dv", bus.data_valid, 0);
        check_val("miss_rv", bus.rd_valid, 0);
        repeat (127) tick();
        check_val("miss_sat", bus.miss_cnt, 255);
        bus.ce_rom_C = 0; bus.ce_rom_read_and_D = 0;

        // abort a load partway through LOAD_D with reset
        rst = 1; tick(); rst = 0;
        check_val("miss_clr", bus.miss_cnt, 0);
        bus.load_start = 1; tick(); bus.load_start = 0;
        check_val("loadc_ready", bus.load_ready, 1);
        for (int i = 0; i < 4; i++) xfer(10'(11 + 10 * i));
        for (int i = 0; i < 50; i++) xfer(rd_word(i));
        bus.load_valid = 0;
        rst = 1; tick(); rst = 0;
        check_val("abort_load_ready", bus.load_ready, 0);
        check_val("abort_ready", bus.ready, 0);
        bus.ce_rom_C = 1; bus.ce_rom_read_and_D = 1; bus.addr_rom_C = 2'd1;
        repeat (2) tick();
        check_val("abort_miss", bus.miss_cnt, 4);
        check_val("abort_dv", bus.data_valid, 0);
        check_val("abort_rv", bus.rd_valid, 0);
        check_val("abort_data", bus.data, 0);
        check_val("abort_d", bus.d_i, 0);
        bus.ce_rom_C = 0; bus.ce_rom_read_and_D = 0;

        // restart at D index 100 with load_valid held high
        bus.load_start = 1; tick(); bus.load_start = 0;
        for (int i = 0; i < 4; i++) xfer(10'(11 + 10 * i));
        for (int i = 0; i < 100; i++) xfer(rd_word(i));
        bus.load_start = 1; bus.load_valid = 1; bus.load_data = 10'h3EE;
        tick();
        bus.load_start = 0;
        check_val("restart_load_ready", bus.load_ready, 1);
        check_val("restart_ready", bus.ready, 0);
        early_done = 0;
        for (int i = 0; i < 4; i++) begin
            xfer(10'(10 + 10 * i));
            if (bus.load_done) early_done++;
        end
        for (int i = 0; i < 255; i++) begin
            xfer(rd_word(i));
            if (bus.load_done) early_done++;
        end
        check_val("early_done", early_done, 0);
        check_val("pre_ready", bus.ready, 0);
        xfer(rd_word(255));
        bus.load_valid = 0;
        check_val("load_done", bus.load_done, 1);
        check_val("ready", bus.ready, 1);
        check_val("ready_load_ready", bus.load_ready, 0);

        // first READY cycle request
        bus.ce_rom_C = 1; bus.addr_rom_C = 2'd2;
        tick();
        check_val("done_pulse", bus.load_done, 0);
        check_val("c2_data", bus.data, 30);
        check_val("c2_dv", bus.data_valid, 1);
        check_val("c2_rv", bus.rd_valid, 0);

        bus.addr_rom_C = 2'd3; bus.ce_rom_read_and_D = 1; bus.addr_rom_read_and_D = 8'h07;
        tick();
        check_val("both_data", bus.data, 40);
        check_val("both_d", bus.d_i, 8'h5D);
        check_val("both_read", bus.read_i, 3);
        check_val("both_dv", bus.data_valid, 1);
        check_val("both_rv", bus.rd_valid, 1);

        for (int k = 0; k < 3; k++) begin
            bus.addr_rom_C = b2b_c[k];
            bus.addr_rom_read_and_D = b2b_addr[k];
            tick();
            check_val("b2b_data", bus.data, b2b_cexp[k]);
            check_val("b2b_d", bus.d_i, b2b_d[k]);
            check_val("b2b_read", bus.read_i, b2b_r[k]);
            check_val("b2b_rv", bus.rd_valid, 1);
        end

        bus.ce_rom_C = 0; bus.ce_rom_read_and_D = 0;
        tick();
        check_val("idle_dv", bus.data_valid, 0);
        check_val("idle_rv", bus.rd_valid, 0);
`ifdef ROM_HOLD_DATA_EN
        check_val("idle_data_hold", bus.data, 10);
        check_val("idle_d_hold", bus.d_i, 8'hDA);
`else
        check_val("idle_data_zero", bus.data, 0);
        check_val("idle_d_zero", bus.d_i, 0);
`endif
        check_val("ready_miss_kept", bus.miss_cnt, 4);

        // load_start while READY restarts the load
        bus.load_start = 1; tick(); bus.load_start = 0;
        check_val("rs_ready", bus.ready, 0);
        check_val("rs_load_ready", bus.load_ready, 1);
        bus.ce_rom_C = 1; tick(); bus.ce_rom_C = 0;
        check_val("rs_miss", bus.miss_cnt, 5);
        check_val("rs_dv", bus.data_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rom_c_read_d_responder.md
# rom_c_read_d_responder

Responder end of the C / read-and-D ROM interface used by the data-fetch stage. Holds the C table (4 × 8-bit) and the read-and-D table (256 × {2-bit read, 8-bit D}). The tables are filled through a streaming load port after reset. Once loaded, the block answers `ce_rom_C` / `ce_rom_read_and_D` requests with registered data one cycle later.

## Interface
- `D_AW`, 8, read-and-D address width; table depth 2^D_AW
- `DW`, 8, width of C entries and D entries
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `load_start` in 1: begin (or restart) table load
- `load_valid` in 1: load word present
- `load_data` in DW+2: C word in [DW-1:0]; read-and-D word as {read[DW+1:DW], D[DW-1:0]}
- `load_ready` out 1: load word accepted this cycle when `load_valid` is high
- `load_done` out 1: one-cycle pulse when load completes
- `ce_rom_C` in 1: C table request
- `addr_rom_C` in 2: C table index (0=A, 1=C, 2=G, 3=T)
- `ce_rom_read_and_D` in 1: read-and-D table request
- `addr_rom_read_and_D` in D_AW: read-and-D index i
- `data` out DW: C entry
- `d_i` out DW: D entry
- `read_i` out 2: read symbol at i
- `data_valid` out 1: `data` valid this cycle
- `rd_valid` out 1: `d_i` / `read_i` valid this cycle
- `ready` out 1: tables loaded, requests served
- `miss_cnt` out 8: saturating count of requests rejected while not ready

## Operation
- States:
  - IDLE: entered on `rst`. `load_start` -> LOAD_C.
  - LOAD_C: `load_idx` 0..3.
  - LOAD_D: `load_idx` 0..2^D_AW-1.
  - READY
- `load_ready` = 1 in LOAD_C and LOAD_D; 0 in IDLE and READY.
- Transfer = `load_valid && load_ready`:
  - LOAD_C writes `C[load_idx] <= load_data[DW-1:0]`.
  - LOAD_D writes `RD[load_idx] <= load_data`.
  - `load_idx` increments on each transfer.
- `load_idx` wrap:
  - After transfer at C index 3: go to LOAD_D, `load_idx` = 0.
  - After transfer at D index 2^D_AW-1: go to READY, `load_idx` = 0, pulse `load_done`.
- `load_start` in any non-IDLE state restarts: LOAD_C, `load_idx` = 0, `ready` = 0. Any transfer in that same cycle is discarded.
- READY:
  - `ce_rom_C` -> next cycle `data = C[addr_rom_C]`, `data_valid` = 1.
  - `ce_rom_read_and_D` -> next cycle `{read_i, d_i} = RD[addr]`, `rd_valid` = 1.
  - The two ports are independent; simultaneous requests are both served in the same cycle.
- Not READY: each asserted ce increments `miss_cnt` (both ce high = +2). Valid outputs stay 0. Count saturates at 255.
- `ready` = (state == READY).

## Timing
- Reset values:
  - State IDLE, `load_idx` 0.
  - `load_ready`, `load_done`, `data_valid`, `rd_valid`, `ready` = 0.
  - `data`, `d_i`, `read_i` = 0.
  - `miss_cnt` = 0.
  - C table cleared to 0; RD table not reset (content undefined until loaded).
- Read latency is exactly 1 cycle; back-to-back requests give one result per cycle.
- `load_done` and the entry to READY occur on the edge after the final transfer. A request presented in the first READY cycle is served.
- `rst` mid-load aborts: IDLE, partial RD content undefined, `ready` = 0, and `load_start` is required again.
- Full load takes 4 + 2^D_AW transfers (260 at default) minimum.

## Configuration
- `ROM_HOLD_DATA_EN` defined: `data` / `d_i` / `read_i` keep their last served value while the matching ce is low or the request is rejected.
- `ROM_HOLD_DATA_EN` undefined: those outputs are 0 in any cycle whose valid bit is 0.
- Valid flags, `miss_cnt` and latency are identical in both builds.

## Test plan
- Reset, then `load_start`, stream C = {10,20,30,40} and RD[i] = {i[1:0], i^8'h5A} -> `load_done` pulses one cycle after the 260th transfer; `ready` = 1.
- READY, `ce_rom_C` = 1, `addr_rom_C` = 2 -> next cycle `data` = 30, `data_valid` = 1.
- READY, both ce high, `addr_rom_C` = 3, `addr_rom_read_and_D` = 8'h07 -> next cycle `data` = 40, `d_i` = 8'h5D, `read_i` = 3, both valid.
- Before load, both ce high for 3 cycles -> `miss_cnt` = 6, valids 0; 130 such cycles -> `miss_cnt` saturates at 255.
- `load_start` at D index 100, with `load_valid` held high -> `load_idx` 0, state LOAD_C; C[0] takes the next word; no `load_done` until 260 further transfers.
- `rst` during LOAD_D, then ce requests -> valids 0, outputs 0, `miss_cnt` counting; with `ROM_HOLD_DATA_EN`, after a served read followed by ce low, `data` holds its prior value.
